// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the instruction ROM and its byte-serial loader.
// Provides bus widths, the zero word, loader state encodings and a byte-lane helper.
package inst_rom_loader_pkg;

    localparam int unsigned InstBus        = 32;
    localparam int unsigned InstAddrBus    = 32;
    localparam int unsigned InstMemNumLog2 = 10;

    localparam logic [InstBus-1:0] ZeroWord = '0;

    typedef enum logic [1:0] {
        LdIdle = 2'd0,
        LdLoad = 2'd1,
        LdErr  = 2'd2
    } ld_state_e;

    // Place a byte into its big-endian lane: index 0 is the MSB.
    function automatic logic [InstBus-1:0] place_byte(input logic [7:0] b, input logic [1:0] k);
        logic [InstBus-1:0] w;
        w = ZeroWord;
        case (k)
            2'd0:    w[31:24] = b;
            2'd1:    w[23:16] = b;
            2'd2:    w[15:8]  = b;
            default: w[7:0]   = b;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Instruction storage: 2^ADDR_W x 32 words, asynchronous read, synchronous write.
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port. Contents are not reset.
module inst_mem_array
    import inst_rom_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = InstMemNumLog2
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [InstBus-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [InstBus-1:0] rdata
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [InstBus-1:0] mem [Depth];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port
    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction memory responder with a byte-serial valid/ready load channel.
// Ports: clk, rst (async active-low); rom_ce_i/rom_addr_i -> rom_data_o same-cycle fetch;
// ld_start_i/ld_valid_i/ld_byte_i/ld_last_i host load channel, ld_ready_o handshake;
// ld_done_o/ld_err_o sticky status, ld_count_o words written; cpu_hold_o holds the core in reset.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = InstMemNumLog2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rom_ce_i,
    input  logic [InstAddrBus-1:0] rom_addr_i,
    output logic [InstBus-1:0]     rom_data_o,
    input  logic                   ld_start_i,
    input  logic                   ld_valid_i,
    input  logic [7:0]             ld_byte_i,
    input  logic                   ld_last_i,
    output logic                   ld_ready_o,
    output logic                   ld_done_o,
    output logic                   ld_err_o,
    output logic [ADDR_W:0]        ld_count_o,
    output logic                   cpu_hold_o
);

    localparam int unsigned CntW = ADDR_W + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(2 ** ADDR_W);

    ld_state_e          state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [InstBus-1:0] word_q, word_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               mem_we;
    logic [InstBus-1:0] mem_wdata;
    logic [InstBus-1:0] mem_rdata;
    logic               addr_in_range;

    inst_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (cnt_q[ADDR_W-1:0]),
        .wdata (mem_wdata),
        .raddr (rom_addr_i[ADDR_W+1:2]),
        .rdata (mem_rdata)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LdIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state, byte packing and memory write
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        word_d    = word_q;
        done_d    = done_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        // Partial word merged with the incoming byte; unfilled lanes stay zero.
        mem_wdata = word_q | place_byte(ld_byte_i, idx_q);

        case (state_q)
            LdIdle: begin
                if (ld_start_i) begin
                    state_d = LdLoad;
                    cnt_d   = '0;
                    idx_d   = '0;
                    word_d  = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end

            LdLoad: begin
                if (ld_start_i) begin
                    // Restart wins over a byte offered in the same cycle.
                    cnt_d  = '0;
                    idx_d  = '0;
                    word_d = '0;
                    done_d = 1'b0;
                    err_d  = 1'b0;
                end else if (ld_valid_i) begin
                    if (cnt_q == DepthCnt) begin
                        err_d   = 1'b1;
                        state_d = LdErr;
                    end else begin
                        if (idx_q == 2'd3 || ld_last_i) begin
                            mem_we = 1'b1;
                            cnt_d  = cnt_q + CntW'(1);
                            idx_d  = '0;
                            word_d = '0;
                        end else begin
                            idx_d  = idx_q + 2'd1;
                            word_d = mem_wdata;
                        end
                        if (ld_last_i) begin
                            state_d = LdIdle;
                            done_d  = 1'b1;
                        end
                    end
                end
            end

            LdErr: begin
                if (ld_start_i) begin
                    state_d = LdLoad;
                    cnt_d   = '0;
                    idx_d   = '0;
                    word_d  = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end

            default: begin
                state_d = LdIdle;
            end
        endcase
    end

    // Fetch is answered only while idle and for addresses inside the array.
    assign addr_in_range = ((rom_addr_i >> (ADDR_W + 2)) == '0);
    assign rom_data_o    = (rom_ce_i && (state_q == LdIdle) && addr_in_range) ? mem_rdata : ZeroWord;

    assign ld_ready_o = (state_q == LdLoad);
    assign cpu_hold_o = (state_q != LdIdle);
    assign ld_done_o  = done_q;
    assign ld_err_o   = err_q;
    assign ld_count_o = cnt_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader: directed and randomized loads checked
// against a word-level reference image built from the byte stream.
module tb_inst_rom_loader;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;

    logic        clk;
    logic        rst;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic [31:0] rom_data_o;
    logic        ld_start_i;
    logic        ld_valid_i;
    logic [7:0]  ld_byte_i;
    logic        ld_last_i;
    logic        ld_ready_o;
    logic        ld_done_o;
    logic        ld_err_o;
    logic [AW:0] ld_count_o;
    logic        cpu_hold_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [DEPTH];
    logic [7:0]  bq [$];

    inst_rom_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_ce_i   (rom_ce_i),
        .rom_addr_i (rom_addr_i),
        .rom_data_o (rom_data_o),
        .ld_start_i (ld_start_i),
        .ld_valid_i (ld_valid_i),
        .ld_byte_i  (ld_byte_i),
        .ld_last_i  (ld_last_i),
        .ld_ready_o (ld_ready_o),
        .ld_done_o  (ld_done_o),
        .ld_err_o   (ld_err_o),
        .ld_count_o (ld_count_o),
        .cpu_hold_o (cpu_hold_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        ld_start_i = 1'b1;
        @(posedge clk);
        #1;
        ld_start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        ld_valid_i = 1'b1;
        ld_byte_i  = b;
        ld_last_i  = last;
        @(posedge clk);
        #1;
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
    endtask

    // Word i of an image is bytes 4i..4i+3, first byte most significant, zero padded.
    function automatic logic [31:0] image_word(input int i);
        logic [31:0] w;
        w = 32'h0;
        for (int j = 0; j < 4; j++) begin
            w = w << 8;
            if (4 * i + j < bq.size()) w = w | 32'(bq[4 * i + j]);
        end
        return w;
    endfunction

    task automatic commit_words(input int nw);
        for (int i = 0; i < nw; i++) mem_m[i] = image_word(i);
    endtask

    task automatic read_word(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        @(negedge clk);
        rom_ce_i   = 1'b1;
        rom_addr_i = addr;
        #1;
        chk(tag, 64'(rom_data_o), 64'(exp));
        rom_ce_i = 1'b0;
    endtask

    task automatic check_idle_status(input string tag, input int cnt, input logic done, input logic err);
        chk({tag, "_count"}, 64'(ld_count_o), 64'(cnt));
        chk({tag, "_done"},  64'(ld_done_o),  64'(done));
        chk({tag, "_err"},   64'(ld_err_o),   64'(err));
        chk({tag, "_hold"},  64'(cpu_hold_o), 64'(0));
        chk({tag, "_ready"}, 64'(ld_ready_o), 64'(0));
    endtask

    initial begin
        int n, nw;
        logic [7:0] b;

        rst        = 1'b0;
        rom_ce_i   = 1'b0;
        rom_addr_i = 32'h0;
        ld_start_i = 1'b0;
        ld_valid_i = 1'b0;
        ld_byte_i  = 8'h0;
        ld_last_i  = 1'b0;
        idle(2);

        // Reset state
        check_idle_status("reset", 0, 1'b0, 1'b0);
        chk("reset_rom_data", 64'(rom_data_o), 64'(0));
        rst = 1'b1;
        idle(1);

        // Clean two-word load
        bq = {8'h34, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h07};
        pulse_start();
        chk("t1_ready", 64'(ld_ready_o), 64'(1));
        chk("t1_hold",  64'(cpu_hold_o), 64'(1));
        rom_ce_i = 1'b1;
        rom_addr_i = 32'h0;
        #1;
        chk("t1_fetch_in_load", 64'(rom_data_o), 64'(0));
        rom_ce_i = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(bq[i], i == 7);
        commit_words(2);
        check_idle_status("t1", 2, 1'b1, 1'b0);
        read_word("t1_word0", 32'h0, 32'h34010005);
        read_word("t1_word1", 32'h4, 32'h20020007);

        // Partial tail
        bq = {8'hAA, 8'hBB, 8'hCC};
        pulse_start();
        chk("t2_done_cleared", 64'(ld_done_o), 64'(0));
        for (int i = 0; i < 3; i++) send_byte(bq[i], i == 2);
        commit_words(1);
        check_idle_status("t2", 1, 1'b1, 1'b0);
        read_word("t2_word0", 32'h0, 32'hAABBCC00);

        // Randomized loads with random valid gaps
        for (int it = 0; it < 6; it++) begin
            n = int'($urandom_range(1, 40));
            bq.delete();
            for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
            pulse_start();
            for (int i = 0; i < n; i++) begin
                send_byte(bq[i], i == n - 1);
                if (i != n - 1) idle(int'($urandom_range(0, 2)));
            end
            nw = (n + 3) / 4;
            commit_words(nw);
            check_idle_status($sformatf("rnd%0d", it), nw, 1'b1, 1'b0);
            for (int i = 0; i < nw; i++)
                read_word($sformatf("rnd%0d_w%0d", it, i), (32'(i) << 2) | 32'($urandom_range(0, 3)), mem_m[i]);
        end

        // Restart with a byte offered alongside the start pulse, then a stalled word
        pulse_start();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        ld_start_i = 1'b1;
        ld_valid_i = 1'b1;
        ld_byte_i  = 8'hEE;
        @(posedge clk);
        #1;
        ld_start_i = 1'b0;
        ld_valid_i = 1'b0;
        chk("t4_count_after_restart", 64'(ld_count_o), 64'(0));
        chk("t4_ready_after_restart", 64'(ld_ready_o), 64'(1));
        bq = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_byte(bq[0], 1'b0);
        send_byte(bq[1], 1'b0);
        idle(3);
        chk("t4_count_stalled", 64'(ld_count_o), 64'(0));
        send_byte(bq[2], 1'b0);
        send_byte(bq[3], 1'b1);
        commit_words(1);
        check_idle_status("t4", 1, 1'b1, 1'b0);
        read_word("t4_word0", 32'h0, 32'hDEADBEEF);

        // Reset mid-load: one full word lands, the buffered fifth byte is lost
        bq = {8'h01, 8'h23, 8'h45, 8'h67, 8'h89};
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(bq[i], 1'b0);
        chk("t5_count_before_rst", 64'(ld_count_o), 64'(1));
        rst = 1'b0;
        #1;
        chk("t5_hold_in_rst", 64'(cpu_hold_o), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_m[0] = 32'h01234567;
        check_idle_status("t5", 0, 1'b0, 1'b0);
        read_word("t5_word0", 32'h0, mem_m[0]);

        // Overflow: fill every word, then one more byte
        bq.delete();
        for (int i = 0; i < 4 * DEPTH; i++) bq.push_back(8'($urandom));
        pulse_start();
        for (int i = 0; i < 4 * DEPTH; i++) send_byte(bq[i], 1'b0);
        chk("t3_count_full", 64'(ld_count_o), 64'(DEPTH));
        chk("t3_err_before", 64'(ld_err_o), 64'(0));
        send_byte(8'hC3, 1'b0);
        commit_words(DEPTH);
        chk("t3_err",   64'(ld_err_o),   64'(1));
        chk("t3_ready", 64'(ld_ready_o), 64'(0));
        chk("t3_hold",  64'(cpu_hold_o), 64'(1));
        chk("t3_done",  64'(ld_done_o),  64'(0));
        chk("t3_count_sat", 64'(ld_count_o), 64'(DEPTH));
        send_byte(8'h3C, 1'b1);
        chk("t3_err_stays", 64'(ld_err_o), 64'(1));
        chk("t3_hold_stays", 64'(cpu_hold_o), 64'(1));
        pulse_start();
        chk("t3_restart_count", 64'(ld_count_o), 64'(0));
        chk("t3_restart_err",   64'(ld_err_o),   64'(0));
        chk("t3_restart_ready", 64'(ld_ready_o), 64'(1));
        send_byte(8'h5A, 1'b1);
        mem_m[0] = 32'h5A000000;
        check_idle_status("t3_final", 1, 1'b1, 1'b0);
        for (int i = 0; i < int'(DEPTH); i++)
            read_word($sformatf("t3_w%0d", i), 32'(i) << 2, mem_m[i]);

        // Fetch edges
        read_word("t6_out_of_range", 32'h0000_1000, 32'h0);
        read_word("t6_high_bit", 32'h8000_0004, 32'h0);
        read_word("t6_low_bits_ignored", 32'h7, mem_m[1]);
        @(negedge clk);
        rom_ce_i   = 1'b0;
        rom_addr_i = 32'h4;
        #1;
        chk("t6_ce_low", 64'(rom_data_o), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
